// File: rtl/scan_index_gen.sv
// ============================================================================
// Module      : scan_index_gen
// Description : Index/enable sequencer for a 4-to-16 one-hot LED decoder.
//               Steps a 4-bit index at a prescaled rate in up, down,
//               ping-pong or hold mode with start/stop, pause and single-step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_index_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  output logic [3:0]       idx,
  output logic             en,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             dir_q, dir_d;    // 0 = up, 1 = down (ping-pong only)
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic [3:0]       adv_idx;
  logic             adv_dir;
  logic             adv_wrap;

  // Position that one advance would produce from the current index/direction.
  always_comb begin
    adv_idx  = idx_q;
    adv_dir  = dir_q;
    adv_wrap = 1'b0;
    case (mode)
      MODE_UP: begin
        adv_idx  = idx_q + 4'd1;
        adv_wrap = (idx_q == 4'hF);
      end
      MODE_DOWN: begin
        adv_idx  = idx_q - 4'd1;
        adv_wrap = (idx_q == 4'h0);
      end
      MODE_PP: begin
        // Endpoint is shown once: reverse on arrival, not on departure.
        // An index already sitting on the far endpoint (entered from another
        // mode) simply bounces back without a second wrap.
        if (!dir_q) begin
          if (idx_q == 4'hF) begin
            adv_idx = 4'hE;
            adv_dir = 1'b1;
          end else begin
            adv_idx = idx_q + 4'd1;
            if (idx_q == 4'hE) begin
              adv_dir  = 1'b1;
              adv_wrap = 1'b1;
            end
          end
        end else begin
          if (idx_q == 4'h0) begin
            adv_idx = 4'h1;
            adv_dir = 1'b0;
          end else begin
            adv_idx = idx_q - 4'd1;
            if (idx_q == 4'h1) begin
              adv_dir  = 1'b0;
              adv_wrap = 1'b1;
            end
          end
        end
      end
      default: ;  // hold: index frozen, prescaler keeps running
    endcase
  end

  // Control FSM, prescaler and index next-state; stop beats start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (start) begin
      state_d = pause ? ST_PAUSE : ST_RUN;
      cnt_d   = '0;
      if (mode == MODE_DOWN) begin
        idx_d = 4'hF;
        dir_d = 1'b1;
      end else begin
        idx_d = 4'h0;
        dir_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
            cnt_d   = '0;
          end else if (cnt_q >= div) begin
            // >= so that lowering div below the running count fires at once
            cnt_d  = '0;
            idx_d  = adv_idx;
            dir_d  = adv_dir;
            wrap_d = adv_wrap;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PAUSE: begin
          cnt_d = '0;
          if (step) begin
            idx_d  = adv_idx;
            dir_d  = adv_dir;
            wrap_d = adv_wrap;
          end
          if (!pause) state_d = ST_RUN;
        end
        default: ;  // idle: index holds its last value
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'h0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign en   = (state_q != ST_IDLE);
  assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_scan_index_gen.sv
// ============================================================================
// Module      : tb_scan_index_gen
// Description : Self-checking bench for scan_index_gen. Expected index/wrap
//               values are queued as stimulus is driven and popped by a
//               monitor whenever the index changes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_index_gen;

  localparam int DIV_W = 24;

  logic             clk;
  logic             rst;
  logic [DIV_W-1:0] div;
  logic [1:0]       mode;
  logic             start;
  logic             stop;
  logic             pause;
  logic             step;
  logic [3:0]       idx;
  logic             en;
  logic             wrap;
  logic             busy;

  typedef struct {
    logic [3:0] idx;
    logic       wrap;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [3:0] prev_idx = 4'h0;

  scan_index_gen #(.DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .div   (div),
    .mode  (mode),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .step  (step),
    .idx   (idx),
    .en    (en),
    .wrap  (wrap),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every index change must match the next queued entry,
  // and wrap must never be high while the index is steady.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      prev_idx = idx;
    end else if (idx !== prev_idx) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got idx=%0d wrap=%0b expected no change", idx, wrap);
      end else begin
        e = sb_q.pop_front();
        if (idx !== e.idx || wrap !== e.wrap) begin
          errors++;
          $display("FAIL sb_advance got idx=%0d wrap=%0b expected idx=%0d wrap=%0b",
                   idx, wrap, e.idx, e.wrap);
        end
      end
      prev_idx = idx;
    end else begin
      checks++;
      if (wrap !== 1'b0) begin
        errors++;
        $display("FAIL sb_wrap_spurious got wrap=%0b idx=%0d expected wrap=0", wrap, idx);
      end
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] i, input logic w);
    exp_t e;
    e.idx  = i;
    e.wrap = w;
    sb_q.push_back(e);
  endtask

  // Advance cycles until the scoreboard has drained or the bound expires.
  task automatic drain(input int bound, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < bound && !ok) begin
      nstep();
      n++;
      if (sb_q.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    nstep();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    nstep();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) nstep();
    checks++;
    if (idx !== 4'h0 || en !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got idx=%0d en=%0b wrap=%0b busy=%0b expected 0 0 0 0",
               idx, en, wrap, busy);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      nstep();
      checks++;
      if (idx !== 4'h0 || en !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got idx=%0d en=%0b wrap=%0b busy=%0b expected 0 0 0 0",
                 i, idx, en, wrap, busy);
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_up();
    int n1, n2, n3;
    bit ok;
    div  = 24'd2;
    mode = 2'b00;
    pulse_start();  // index already 0, reload is invisible
    checks++;
    if (en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL up_en got en=%0b busy=%0b expected 1 1", en, busy);
    end
    push(4'd1, 1'b0);
    drain(20, n1, ok);
    checks++;
    if (!ok || n1 != 3) begin
      errors++;
      $display("FAIL up_first got cycles=%0d drained=%0b expected cycles=3", n1, ok);
    end
    for (int i = 2; i < 16; i++) push(4'(i), 1'b0);
    push(4'd0, 1'b1);
    drain(200, n2, ok);
    push(4'd1, 1'b0);
    drain(20, n3, ok);
    checks++;
    if (!ok || n2 + n3 != 48) begin
      errors++;
      $display("FAIL up_lap got cycles=%0d drained=%0b expected cycles=48", n2 + n3, ok);
    end
    pulse_stop();
  endtask

  task automatic test_down_stop();
    int n;
    bit ok;
    div  = 24'd0;
    mode = 2'b01;
    push(4'd15, 1'b0);
    pulse_start();
    checks++;
    if (en !== 1'b1 || idx !== 4'd15) begin
      errors++;
      $display("FAIL down_start got en=%0b idx=%0d expected en=1 idx=15", en, idx);
    end
    for (int i = 14; i >= 0; i--) push(4'(i), 1'b0);
    push(4'd15, 1'b1);
    for (int i = 14; i >= 7; i--) push(4'(i), 1'b0);
    drain(100, n, ok);
    checks++;
    if (!ok || n != 24) begin
      errors++;
      $display("FAIL down_seq got cycles=%0d drained=%0b expected cycles=24", n, ok);
    end
    pulse_stop();
    checks++;
    if (en !== 1'b0 || idx !== 4'd7 || busy !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_stop got en=%0b idx=%0d busy=%0b wrap=%0b expected 0 7 0 0",
               en, idx, busy, wrap);
    end
  endtask

  task automatic test_pingpong();
    int n;
    bit ok;
    div  = 24'd0;
    mode = 2'b10;
    push(4'd0, 1'b0);
    pulse_start();
    for (int i = 1; i < 15; i++) push(4'(i), 1'b0);
    push(4'd15, 1'b1);
    for (int i = 14; i >= 1; i--) push(4'(i), 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'b0);
    drain(100, n, ok);
    checks++;
    if (!ok || n != 31) begin
      errors++;
      $display("FAIL pp_seq got cycles=%0d drained=%0b expected cycles=31", n, ok);
    end
    pulse_stop();
  endtask

  task automatic test_pause_step();
    int n;
    bit ok;
    div  = 24'd3;
    mode = 2'b00;
    push(4'd0, 1'b0);
    pulse_start();
    for (int i = 1; i <= 5; i++) push(4'(i), 1'b0);
    drain(100, n, ok);
    checks++;
    if (!ok || n != 20) begin
      errors++;
      $display("FAIL pause_run got cycles=%0d drained=%0b expected cycles=20", n, ok);
    end
    pause = 1'b1;
    nstep();
    for (int i = 0; i < 6; i++) begin
      nstep();
      checks++;
      if (idx !== 4'd5 || en !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL pause_hold got idx=%0d en=%0b busy=%0b expected 5 1 1", idx, en, busy);
      end
    end
    for (int s = 0; s < 3; s++) begin
      push(4'(6 + s), 1'b0);
      step = 1'b1;
      nstep();
      step = 1'b0;
      nstep();
      nstep();
    end
    checks++;
    if (sb_q.size() != 0 || idx !== 4'd8) begin
      errors++;
      $display("FAIL pause_step got idx=%0d pending=%0d expected idx=8 pending=0", idx, sb_q.size());
    end
    pause = 1'b0;
    push(4'd9, 1'b0);
    drain(20, n, ok);
    checks++;
    if (!ok || n != 5) begin
      errors++;
      $display("FAIL pause_resume got cycles=%0d drained=%0b expected cycles=5", n, ok);
    end
    pulse_stop();
  endtask

  task automatic test_start_stop_same();
    start = 1'b1;
    stop  = 1'b1;
    nstep();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b0 || en !== 1'b0 || idx !== 4'd9) begin
        errors++;
        $display("FAIL start_stop got busy=%0b en=%0b idx=%0d expected 0 0 9", busy, en, idx);
      end
      nstep();
    end
  endtask

  task automatic test_div_lower();
    div  = 24'd100;
    mode = 2'b00;
    push(4'd0, 1'b0);
    pulse_start();
    repeat (50) nstep();
    checks++;
    if (idx !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL div_wait got idx=%0d busy=%0b expected idx=0 busy=1", idx, busy);
    end
    div = 24'd1;
    push(4'd1, 1'b0);
    nstep();
    checks++;
    if (idx !== 4'd1) begin
      errors++;
      $display("FAIL div_lower got idx=%0d expected idx=1", idx);
    end
    pulse_stop();
  endtask

  task automatic test_async_reset();
    mon_en = 1'b0;
    div  = 24'd0;
    mode = 2'b00;
    pulse_start();
    repeat (5) nstep();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (idx !== 4'h0 || en !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got idx=%0d en=%0b wrap=%0b busy=%0b expected 0 0 0 0",
               idx, en, wrap, busy);
    end
    nstep();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      nstep();
      checks++;
      if (idx !== 4'h0 || en !== 1'b0 || wrap !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL async_after got idx=%0d en=%0b wrap=%0b busy=%0b expected 0 0 0 0",
                 idx, en, wrap, busy);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    div   = '0;
    mode  = 2'b00;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    step  = 1'b0;
    test_reset();
    test_up();
    test_down_stop();
    test_pingpong();
    test_pause_step();
    test_start_stop_same();
    test_div_lower();
    test_async_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got pending=%0d expected pending=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
